// File: rtl/lz4_hash_match.sv
// lz4_hash_match: LZ4 match-candidate finder.
// Pulls one 4-byte window at a time from the byte-addressing stage, hashes it,
// looks up the last position/data stored for that bucket and emits one
// candidate record per window over a valid/ready handshake. The bucket is
// always overwritten with the newest window after the lookup.
module lz4_hash_match #(
  parameter int HASH_BITS  = 10,
  parameter int MAX_OFFSET = 65535
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        enable,
  input  logic        byte4_busy,
  input  logic [31:0] byte4_shift,
  input  logic [31:0] abs_addr,
  input  logic        byte4_svalid,
  output logic        rd_shift_en,
  output logic        cand_valid,
  input  logic        cand_ready,
  output logic        cand_match,
  output logic [15:0] cand_offset,
  output logic [31:0] cand_pos,
  output logic [31:0] cand_data
);

  localparam int          DEPTH        = 1 << HASH_BITS;
  localparam logic [31:0] MAX_OFFSET_C = 32'(MAX_OFFSET);
  localparam logic [31:0] HASH_MULT    = 32'h9E3779B1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HASH   = 3'd3,
    ST_LOOKUP = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  // Multiplicative hash: top HASH_BITS of the low 32 bits of the product.
  function automatic logic [HASH_BITS-1:0] hash_idx(input logic [31:0] w);
    logic [31:0] prod;
    prod = w * HASH_MULT;
    return prod[31:32-HASH_BITS];
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [31:0]            win_r;
  logic [31:0]            pos_r;
  logic [HASH_BITS-1:0]   idx_r;
  logic [HASH_BITS-1:0]   hash_s;
  logic                   rd_vld_r;
  logic [63:0]            rd_data_r;

  // Position/data storage is never cleared; only the valid bits are.
  logic [63:0]            tbl_mem [DEPTH];
  logic [DEPTH-1:0]       tbl_vld_r;

  logic [31:0]            dist_s;
  logic                   match_s;

  logic                   rd_shift_en_r;
  logic                   cand_valid_r;
  logic                   cand_match_r;
  logic [15:0]            cand_offset_r;
  logic [31:0]            cand_pos_r;
  logic [31:0]            cand_data_r;

  assign hash_s = hash_idx(win_r);

  // Next-state logic: enable low always returns to IDLE and drops the window.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!byte4_busy) state_nxt_s = ST_REQ;
          else             state_nxt_s = ST_IDLE;
        end
        ST_REQ:  state_nxt_s = ST_WAIT;
        ST_WAIT: begin
          if (byte4_svalid) state_nxt_s = ST_HASH;
          else              state_nxt_s = ST_WAIT;
        end
        ST_HASH:   state_nxt_s = ST_LOOKUP;
        ST_LOOKUP: state_nxt_s = ST_OUT;
        ST_OUT: begin
          if (cand_ready) state_nxt_s = ST_IDLE;
          else            state_nxt_s = ST_OUT;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Match decision on the bucket read back in LOOKUP; d == 0 is never a match.
  always_comb begin
    dist_s  = pos_r - rd_data_r[63:32];
    match_s = rd_vld_r && (rd_data_r[31:0] == win_r) &&
              (dist_s != 32'd0) && (dist_s <= MAX_OFFSET_C);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Window capture and hash index / bucket-valid pipeline registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      win_r    <= 32'd0;
      pos_r    <= 32'd0;
      idx_r    <= '0;
      rd_vld_r <= 1'b0;
    end else if (!enable) begin
      rd_vld_r <= 1'b0;
    end else begin
      if (state_r == ST_WAIT && byte4_svalid) begin
        win_r <= byte4_shift;
        pos_r <= abs_addr;
      end
      if (state_r == ST_HASH) begin
        idx_r    <= hash_s;
        rd_vld_r <= tbl_vld_r[hash_s];
      end
    end
  end

  // Table storage: synchronous read in HASH, write-back of the newest window in LOOKUP.
  always_ff @(posedge clk) begin
    if (state_r == ST_HASH) begin
      rd_data_r <= tbl_mem[hash_s];
    end
    if (enable && state_r == ST_LOOKUP) begin
      tbl_mem[idx_r] <= {pos_r, win_r};
    end
  end

  // Bucket valid bits: cleared by reset and enable low, set on every write-back.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tbl_vld_r <= '0;
    end else if (!enable) begin
      tbl_vld_r <= '0;
    end else if (state_r == ST_LOOKUP) begin
      tbl_vld_r[idx_r] <= 1'b1;
    end
  end

  // Registered outputs: shift request mirrors REQ, candidate record loaded in LOOKUP.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_shift_en_r <= 1'b0;
      cand_valid_r  <= 1'b0;
      cand_match_r  <= 1'b0;
      cand_offset_r <= 16'd0;
      cand_pos_r    <= 32'd0;
      cand_data_r   <= 32'd0;
    end else if (!enable) begin
      rd_shift_en_r <= 1'b0;
      cand_valid_r  <= 1'b0;
      cand_match_r  <= 1'b0;
      cand_offset_r <= 16'd0;
      cand_pos_r    <= 32'd0;
      cand_data_r   <= 32'd0;
    end else begin
      rd_shift_en_r <= (state_nxt_s == ST_REQ);
      case (state_r)
        ST_LOOKUP: begin
          cand_valid_r  <= 1'b1;
          cand_match_r  <= match_s;
          cand_offset_r <= match_s ? dist_s[15:0] : 16'd0;
          cand_pos_r    <= pos_r;
          cand_data_r   <= win_r;
        end
        ST_OUT: begin
          if (cand_ready) cand_valid_r <= 1'b0;
          else            cand_valid_r <= 1'b1;
        end
        default: cand_valid_r <= 1'b0;
      endcase
    end
  end

  assign rd_shift_en = rd_shift_en_r;
  assign cand_valid  = cand_valid_r;
  assign cand_match  = cand_match_r;
  assign cand_offset = cand_offset_r;
  assign cand_pos    = cand_pos_r;
  assign cand_data   = cand_data_r;

endmodule

// File: doc/lz4_hash_match.md
# lz4_hash_match

Match-candidate finder directly downstream of the byte-addressing stage in the LZ4 compressor. It pulls the sliding 4-byte window one byte at a time with `rd_shift_en`, hashes each window, and looks the hash up in an internal hash table that stores the last position and data for each bucket. It emits one candidate record per window (match flag, offset, position, data) to the sequence encoder through a valid/ready handshake.

## Interface

Parameters:
- `HASH_BITS`, default 10: hash table index width; the table has 2^HASH_BITS entries.
- `MAX_OFFSET`, default 65535: largest legal match offset.

Ports:
- `clk`  in  1  clock.
- `rstN`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  block enable, shared with the upstream stage. Low means synchronous clear.
- `byte4_busy`  in  1  upstream not ready; no shift may be requested while high.
- `byte4_shift`  in  32  current 4-byte window.
- `abs_addr`  in  32  position of the window; valid together with `byte4_svalid`.
- `byte4_svalid`  in  1  one-cycle pulse, one cycle after `rd_shift_en`: a new window is present.
- `rd_shift_en`  out  1  one-cycle request to advance the window by one byte.
- `cand_valid`  out  1  candidate record valid.
- `cand_ready`  in  1  downstream accepts the record.
- `cand_match`  out  1  a match was found.
- `cand_offset`  out  16  `pos - stored_pos`. Forced to 0 when `cand_match` is 0.
- `cand_pos`  out  32  `abs_addr` captured for this window.
- `cand_data`  out  32  the window value.

## Operation

- FSM states: IDLE, REQ, WAIT, HASH, LOOKUP, OUT. Only one window is in flight at a time.
- IDLE → REQ when `enable` is high and `byte4_busy` is low.
- REQ: drive `rd_shift_en` = 1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `byte4_svalid` is seen. On that cycle:
  - latch `win_r` <= `byte4_shift` and `pos_r` <= `abs_addr`;
  - go to HASH.
- HASH: compute the index `idx` = bits [31:32-HASH_BITS] of the low 32 bits of (`win_r` * 32'h9E3779B1). Issue a synchronous read of `table[idx]`, register `idx`, and go to LOOKUP.
- LOOKUP:
  - Read data is {`vld`, `spos[31:0]`, `sdata[31:0]`}.
  - Compute `d` = `pos_r` - `spos` with 32-bit wrap.
  - `match` = `vld` && (`sdata` == `win_r`) && (`d` >= 1) && (`d` <= MAX_OFFSET).
  - Write `table[idx]` <= {1, `pos_r`, `win_r`}. The write happens whether or not there was a match, so the newest entry always replaces the older one. The read completes before the write.
  - Register the `cand_*` outputs and go to OUT.
- OUT: hold `cand_valid` = 1 with stable outputs until `cand_ready` = 1, then go to IDLE.
- Valid bits are held in flip-flops. All of them are cleared by reset and by `enable` = 0. Position and data storage is not cleared.
- `enable` = 0 in any state:
  - next state is IDLE;
  - `rd_shift_en`, `cand_valid` and all `cand_*` fields go to 0;
  - all valid bits are cleared;
  - any in-flight window is dropped.
- `byte4_busy` is sampled only in IDLE. Once REQ has been entered, the sequence completes.

## Timing

- Reset values: `rd_shift_en` = 0, `cand_valid` = 0, `cand_match` = 0, `cand_offset` = 0, `cand_pos` = 0, `cand_data` = 0; FSM in IDLE; all table valid bits = 0.
- Cycle sequence, with `rd_shift_en` high at cycle T:
  - `byte4_svalid` arrives at T+1;
  - HASH at T+2;
  - LOOKUP at T+3;
  - `cand_valid` first high at T+4.
- With `cand_ready` held high:
  - the handshake completes at T+4;
  - the FSM is in IDLE at T+5;
  - the next `rd_shift_en` is at T+6.
  - Peak throughput is therefore one window per 6 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- `cand_offset` = `d[15:0]`. This is exact because `d` <= MAX_OFFSET <= 65535 whenever `cand_match` = 1.
- Position wrap: `abs_addr` wrapping past 32'hFFFFFFFF still yields a correct `d` through modular subtraction.
- `d` = 0 (the same position seen again, e.g. after a wrap of the full address space) is not a match.

## Test plan

- Reset then enable with window sequence 0x41424344 at pos 0 through 7, where the window at pos 4 is 0x41424344 again: pos 0 gives `cand_match` = 0; pos 4 gives `cand_match` = 1 and `cand_offset` = 4.
- Handshake timing: `rd_shift_en` at cycle T → `cand_valid` at T+4. With `cand_ready` low for 5 cycles, `rd_shift_en` stays 0 and the outputs stay stable; the next `rd_shift_en` comes 2 cycles after the handshake.
- Offset limit: identical data at pos 100 and pos 65635 (`d` = 65535) → match with `cand_offset` = 65535. Identical data at pos 100 and pos 65636 → `cand_match` = 0 and `cand_offset` = 0.
- Collision: two different windows with the same `idx` → second gives `cand_match` = 0. A third window equal to the second → matches the second's position, proving the overwrite.
- `byte4_busy` high for 10 cycles in IDLE → no `rd_shift_en`. Deassert it → `rd_shift_en` on the next cycle.
- `enable` low for 1 cycle while in LOOKUP → `cand_valid` never asserts for that window, and all valid bits are cleared. Repeating a window seen before the clear → `cand_match` = 0.
